// File: rtl/mac_pkg.sv
// Shared widths, psum limits and FSM state type for the MAC accumulation lane.
package mac_pkg;

    localparam int DATA_W = 8;
    localparam int PSUM_W = 24;

    localparam logic signed [PSUM_W-1:0] PSUM_MAX = 24'sh7FFFFF;
    localparam logic signed [PSUM_W-1:0] PSUM_MIN = 24'sh800000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/mac_accum_seq_mac.sv
// Combinational 8x8+24 MAC: signed int8 product, sign-extended, added to a 24-bit psum (wraps).
module mac_accum_seq_mac
    import mac_pkg::*;
(
    input  logic signed [DATA_W-1:0] ifmap,
    input  logic signed [DATA_W-1:0] filter,
    input  logic signed [PSUM_W-1:0] psum_in,
    output logic signed [PSUM_W-1:0] updated_psum
);

    logic signed [2*DATA_W-1:0] product;
    logic signed [PSUM_W-1:0]   product_ext;

    // 16 bits hold every int8 product exactly, including -128 * -128 = +16384.
    assign product     = ifmap * filter;
    assign product_ext = {{(PSUM_W-2*DATA_W){product[2*DATA_W-1]}}, product};
    assign updated_psum = psum_in + product_ext;

endmodule

// File: rtl/mac_accum_seq.sv
// One PE accumulation lane: seeds a psum, accumulates KLEN int8 pairs through the MAC, hands the result on.
// Build option ACC_SAT_EN: saturate the running psum instead of wrapping and report it on sat_flag.
module mac_accum_seq
    import mac_pkg::*;
#(
    parameter int KLEN  = 9,
    parameter int CNT_W = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic signed [PSUM_W-1:0] psum_init,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] ifmap,
    input  logic signed [DATA_W-1:0] filter,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [PSUM_W-1:0] result,
    output logic                     busy,
    output logic                     sat_flag,
    output state_t                   dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high.
    // in_ready depends only on state; out_valid/result stay stable until out_ready takes them.

    state_t                   state;
    state_t                   state_nxt;
    logic [CNT_W-1:0]         cnt;
    logic signed [PSUM_W-1:0] psum_q;
    logic signed [PSUM_W-1:0] psum_nxt;
    logic signed [PSUM_W-1:0] mac_psum_in;
    logic signed [PSUM_W-1:0] mac_out;
    logic                     accept;
    logic                     last_pair;
    logic                     start_ok;

    assign accept    = in_valid && in_ready;
    assign last_pair = (cnt == CNT_W'(KLEN - 1));
    assign start_ok  = (state == IDLE) && start;

    mac_accum_seq_mac u_mac (
        .ifmap       (ifmap),
        .filter      (filter),
        .psum_in     (mac_psum_in),
        .updated_psum(mac_out)
    );

`ifdef ACC_SAT_EN
    logic signed [PSUM_W-1:0] sum;
    logic                     step_ovf;
    logic                     sat_q;

    // MAC runs with a zero psum, so its output is the sign-extended product alone.
    assign mac_psum_in = '0;
    assign sum         = psum_q + mac_out;
    assign step_ovf    = (psum_q[PSUM_W-1] == mac_out[PSUM_W-1]) &&
                         (sum[PSUM_W-1] != psum_q[PSUM_W-1]);
    assign psum_nxt    = !step_ovf ? sum : (psum_q[PSUM_W-1] ? PSUM_MIN : PSUM_MAX);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sat_q <= 1'b0;
        end else if (start_ok) begin
            sat_q <= 1'b0;
        end else if (accept && step_ovf) begin
            sat_q <= 1'b1;
        end
    end

    assign sat_flag = sat_q;
`else
    assign mac_psum_in = psum_q;
    assign psum_nxt    = mac_out;
    assign sat_flag    = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = ACCUM;
            ACCUM:   if (accept && last_pair) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == ACCUM);
        out_valid = (state == DONE);
        busy      = (state != IDLE);
        dbg_state = state;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            psum_q <= '0;
            cnt    <= '0;
            result <= '0;
        end else if (start_ok) begin
            psum_q <= psum_init;
            cnt    <= '0;
        end else if (accept) begin
            psum_q <= psum_nxt;
            if (last_pair) begin
                result <= psum_nxt;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_mac_accum_seq.sv
// Bench for mac_accum_seq: lane 0 built with KLEN=9, lane 1 with KLEN=1, checked against an arithmetic model.
// Honours ACC_SAT_EN the same way as the design (saturating model when defined).
module tb_mac_accum_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                  rst_n;
    logic                  start     [2];
    logic [23:0]           psum_init [2];
    logic                  in_valid  [2];
    logic                  in_ready  [2];
    logic [7:0]            ifmap     [2];
    logic [7:0]            filter    [2];
    logic                  out_valid [2];
    logic                  out_ready [2];
    logic [23:0]           result    [2];
    logic                  busy      [2];
    logic                  sat_flag  [2];
    mac_pkg::state_t       dbg_state [2];

    mac_accum_seq #(.KLEN(9), .CNT_W(8)) u_dut9 (
        .clk(clk), .rst_n(rst_n), .start(start[0]), .psum_init(psum_init[0]),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]), .ifmap(ifmap[0]), .filter(filter[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]), .result(result[0]),
        .busy(busy[0]), .sat_flag(sat_flag[0]), .dbg_state(dbg_state[0])
    );

    mac_accum_seq #(.KLEN(1), .CNT_W(8)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start[1]), .psum_init(psum_init[1]),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]), .ifmap(ifmap[1]), .filter(filter[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]), .result(result[1]),
        .busy(busy[1]), .sat_flag(sat_flag[1]), .dbg_state(dbg_state[1])
    );

    int n_vec;
    int n_bad;

    // Model: exact integer accumulation, then 24-bit wrap or clamp.
    longint      m_acc [2];
    bit          m_sat [2];
    int          m_cnt [2];
    logic [24:0] exp_q0[$];
    logic [24:0] exp_q1[$];

    logic [23:0] last_res [2];
    logic        last_sat [2];
    logic [23:0] prev_res [2];
    bit          prev_hold[2];

    function automatic int klen_of(int l);
        return (l == 0) ? 9 : 1;
    endfunction

    task automatic check(input string name, input int l, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s lane%0d: got %0h expected %0h", name, l, got, exp);
        end
    endtask

    task automatic fail_now(input string name, input int l);
        n_vec++;
        n_bad++;
        $display("FAIL %s lane%0d: event did not match expectation", name, l);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic model_step(input int l, input logic [7:0] a, input logic [7:0] b);
        logic [23:0] w;
        logic [24:0] e;
        m_acc[l] = m_acc[l] + longint'($signed(a)) * longint'($signed(b));
`ifdef ACC_SAT_EN
        if (m_acc[l] > 8388607) begin
            m_acc[l] = 8388607;
            m_sat[l] = 1'b1;
        end else if (m_acc[l] < -8388608) begin
            m_acc[l] = -8388608;
            m_sat[l] = 1'b1;
        end
`else
        w = m_acc[l][23:0];
        m_acc[l] = longint'($signed(w));
`endif
        m_cnt[l]++;
        if (m_cnt[l] == klen_of(l)) begin
            e = {m_sat[l], m_acc[l][23:0]};
            if (l == 0) exp_q0.push_back(e);
            else exp_q1.push_back(e);
            check("out_valid one cycle after last accept", l, out_valid[l], 1);
        end
    endtask

    task automatic do_start(input int l, input logic [23:0] init);
        check("idle before start", l, busy[l], 0);
        start[l] = 1'b1;
        psum_init[l] = init;
        @(posedge clk);
        #1;
        start[l] = 1'b0;
        psum_init[l] = 24'($urandom);
        m_acc[l] = longint'($signed(init));
        m_sat[l] = 1'b0;
        m_cnt[l] = 0;
        check("busy after start", l, busy[l], 1);
        check("sat_flag cleared by start", l, sat_flag[l], 0);
    endtask

    task automatic poke_start(input int l);
        start[l] = 1'b1;
        psum_init[l] = 24'h055555;
        @(posedge clk);
        #1;
        start[l] = 1'b0;
    endtask

    task automatic send_pair(input int l, input logic [7:0] a, input logic [7:0] b);
        int n;
        in_valid[l] = 1'b1;
        ifmap[l] = a;
        filter[l] = b;
        n = 0;
        while (!in_ready[l] && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!in_ready[l]) begin
            fail_now("in_ready timeout", l);
        end else begin
            @(posedge clk);
            #1;
            model_step(l, a, b);
        end
        in_valid[l] = 1'b0;
        ifmap[l] = 8'($urandom);
        filter[l] = 8'($urandom);
    endtask

    task automatic wait_result(input int l, input bit rand_ready);
        int  n;
        bit  hs;
        bit  got;
        n = 0;
        got = 1'b0;
        while (!got && n < 200) begin
            out_ready[l] = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            hs = out_valid[l] && out_ready[l];
            @(posedge clk);
            #1;
            got = hs;
            n++;
        end
        out_ready[l] = 1'b0;
        if (!got) fail_now("result timeout", l);
    endtask

    task automatic check_reset_state(input int l);
        check("reset out_valid", l, out_valid[l], 0);
        check("reset in_ready", l, in_ready[l], 0);
        check("reset busy", l, busy[l], 0);
        check("reset result", l, result[l], 0);
        check("reset sat_flag", l, sat_flag[l], 0);
        check("reset state", l, dbg_state[l], mac_pkg::IDLE);
    endtask

    task automatic random_run(input int l, input bit gaps, input bit bp);
        do_start(l, 24'($urandom));
        for (int k = 0; k < klen_of(l); k++) begin
            send_pair(l, 8'($urandom), 8'($urandom));
            if (gaps) idle($urandom_range(0, 2));
        end
        wait_result(l, bp);
    endtask

    // Compare process: every cycle, checks DONE behaviour and scores each delivered result.
    always @(negedge clk) begin
        logic [24:0] e;
        if (!rst_n) begin
            prev_hold[0] <= 1'b0;
            prev_hold[1] <= 1'b0;
        end else begin
            for (int l = 0; l < 2; l++) begin
                if (prev_hold[l]) begin
                    check("out_valid held under backpressure", l, out_valid[l], 1);
                    check("result held under backpressure", l, result[l], prev_res[l]);
                end
                if (out_valid[l]) begin
                    check("in_ready low in DONE", l, in_ready[l], 0);
                    check("busy high in DONE", l, busy[l], 1);
                end
                if (out_valid[l] && out_ready[l]) begin
                    if ((l == 0 && exp_q0.size() == 0) || (l == 1 && exp_q1.size() == 0)) begin
                        fail_now("unexpected result", l);
                    end else begin
                        if (l == 0) e = exp_q0.pop_front();
                        else e = exp_q1.pop_front();
                        check("result", l, result[l], e[23:0]);
                        check("sat_flag", l, sat_flag[l], e[24]);
                        last_res[l] <= result[l];
                        last_sat[l] <= sat_flag[l];
                    end
                end
                prev_hold[l] <= out_valid[l] && !out_ready[l];
                prev_res[l]  <= result[l];
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached before the end of the test");
        $fatal(1, "time limit");
    end

    initial begin
        n_vec = 0;
        n_bad = 0;
        rst_n = 1'b0;
        for (int l = 0; l < 2; l++) begin
            start[l] = 1'b0;
            psum_init[l] = '0;
            in_valid[l] = 1'b0;
            ifmap[l] = '0;
            filter[l] = '0;
            out_ready[l] = 1'b0;
            m_acc[l] = 0;
            m_sat[l] = 1'b0;
            m_cnt[l] = 0;
        end
        idle(3);
        check_reset_state(0);
        check_reset_state(1);
        rst_n = 1'b1;
        idle(2);

        // in_valid in IDLE is not accepted
        in_valid[0] = 1'b1;
        ifmap[0] = 8'd7;
        filter[0] = 8'd7;
        idle(2);
        check("in_ready in IDLE", 0, in_ready[0], 0);
        check("busy in IDLE", 0, busy[0], 0);
        in_valid[0] = 1'b0;

        // nominal: nine (3,4) from 0 -> 108
        do_start(0, 24'd0);
        repeat (9) send_pair(0, 8'd3, 8'd4);
        wait_result(0, 1'b0);
        check("nominal literal", 0, last_res[0], 24'h00006C);
        check("out_valid single cycle", 0, out_valid[0], 0);

        // corner operands
        do_start(0, 24'hFFFFFB);
        repeat (9) send_pair(0, 8'h80, 8'h80);
        wait_result(0, 1'b0);
        check("-128*-128 literal", 0, last_res[0], 24'h023FFB);
        do_start(1, 24'd0);
        send_pair(1, 8'h80, 8'h7F);
        wait_result(1, 1'b0);
        check("-128*127 literal", 1, last_res[1], 24'hFFC080);

        // toggled in_valid plus 5 cycles of backpressure
        do_start(0, 24'd0);
        for (int k = 0; k < 9; k++) begin
            send_pair(0, 8'd3, 8'd4);
            if (k < 8) idle(1);
        end
        idle(5);
        wait_result(0, 1'b0);
        check("stalled run literal", 0, last_res[0], 24'h00006C);

        // reset after four accepts discards the run
        do_start(0, 24'($urandom));
        repeat (4) send_pair(0, 8'($urandom), 8'($urandom));
        rst_n = 1'b0;
        idle(1);
        check_reset_state(0);
        m_cnt[0] = 0;
        rst_n = 1'b1;
        idle(1);
        do_start(0, 24'd10);
        repeat (9) send_pair(0, 8'd1, 8'd1);
        wait_result(0, 1'b0);
        check("after reset literal", 0, last_res[0], 24'd19);

        // overflow on the KLEN=1 lane
        do_start(1, 24'h7FFFF0);
        send_pair(1, 8'd127, 8'd127);
        wait_result(1, 1'b0);
`ifdef ACC_SAT_EN
        check("positive overflow literal", 1, last_res[1], 24'h7FFFFF);
        check("sat_flag sticky in IDLE", 1, sat_flag[1], 1);
`else
        check("positive overflow literal", 1, last_res[1], 24'h803EF1);
        check("sat_flag tied low", 1, sat_flag[1], 0);
`endif
        do_start(1, 24'h800010);
        send_pair(1, 8'h80, 8'h7F);
        wait_result(1, 1'b0);
`ifdef ACC_SAT_EN
        check("negative overflow literal", 1, last_res[1], 24'h800000);
`else
        check("negative overflow literal", 1, last_res[1], 24'h7FC090);
`endif

        // start ignored in ACCUM and DONE
        do_start(0, 24'd100);
        repeat (3) send_pair(0, 8'd2, 8'd5);
        poke_start(0);
        repeat (6) send_pair(0, 8'd2, 8'd5);
        idle(1);
        poke_start(0);
        idle(1);
        wait_result(0, 1'b0);
        check("ignored start literal", 0, last_res[0], 24'd190);
        check("IDLE after DONE", 0, busy[0], 0);
        idle(1);
        check("no restart from DONE start", 0, busy[0], 0);

        // randomized runs with gaps and backpressure
        for (int r = 0; r < 24; r++) begin
            random_run($urandom_range(0, 1), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        idle(3);
        check("pending results", 0, exp_q0.size() + exp_q1.size(), 0);
        check("final out_valid", 0, out_valid[0], 0);
        check("final out_valid", 1, out_valid[1], 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/mac_accum_seq.md
Name: mac_accum_seq

Overview:
- Sequencer and accumulator wrapped around the combinational 8x8+24 MAC datapath.
- Accepts a stream of signed int8 (ifmap, filter) pairs over a valid/ready handshake and seeds the partial sum from a bias/initial value.
- Feeds each pair plus the registered psum into MAC and registers updated_psum.
- After KLEN pairs, presents the 24-bit result downstream on a valid/ready handshake. This forms one PE accumulation lane.

Parameters:
- KLEN, 9, number of products accumulated per result (3x3 kernel); legal range 1..255
- DATA_W, 8, ifmap/filter width; fixed by MAC
- PSUM_W, 24, psum width; fixed by MAC
- CNT_W, 8, pair counter width; must satisfy 2^CNT_W > KLEN

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  synchronous active-low reset, sampled on rising clk
- start  in  1  one-cycle request to begin a new accumulation; honoured only in IDLE
- psum_init  in  24  signed initial psum (bias), captured when start is honoured
- in_valid  in  1  ifmap/filter pair valid
- in_ready  out  1  block accepts a pair this cycle
- ifmap  in  8  signed activation
- filter  in  8  signed weight
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- result  out  24  signed accumulated psum
- busy  out  1  high in ACCUM or DONE
- sat_flag  out  1  result was clamped (ACC_SAT_EN only; tied 0 otherwise)

Behaviour:
- Reset (rst_n=0 at clk edge):
  - state=IDLE; psum_q=0, cnt=0, out_valid=0, result=0, sat_flag=0.
  - Reset mid-accumulation discards all partial state; no result is emitted.
- IDLE:
  - in_ready=0, busy=0.
  - start=1: psum_q<=psum_init, cnt<=0, sat_flag<=0, go ACCUM.
  - in_valid is ignored in IDLE.
- ACCUM:
  - in_ready=1; a pair is accepted on in_valid&in_ready.
  - On accept: psum_q<=MAC(ifmap, filter, psum_q).
  - If cnt==KLEN-1: go DONE, out_valid<=1, result<=new psum. Otherwise cnt<=cnt+1.
  - Gaps in in_valid stall without side effects. start is ignored.
- DONE:
  - in_ready=0; result and out_valid held stable until out_ready=1.
  - On out_valid&out_ready: out_valid<=0, go IDLE.
  - A start asserted in the same cycle is ignored; it must be reissued in IDLE.
- Latency: result valid 1 cycle after the clock edge accepting the KLEN-th pair. Minimum turnaround is start to result in KLEN+1 cycles, then 1 cycle in IDLE.
- Throughput: 1 pair/cycle in ACCUM.
- KLEN=1: the first accepted pair goes directly to DONE.
- Arithmetic:
  - Product is the signed 16-bit value, sign-extended to 24 bits.
  - The sum wraps modulo 2^24 unless ACC_SAT_EN is defined.
  - -128*-128 = +16384 must be exact.

Optional Feature:
- Macro: ACC_SAT_EN.
- Defined:
  - Each accumulate step detects signed overflow: both operands share a sign and the sum's sign differs.
  - On overflow, clamp to 0x7FFFFF (positive) or 0x800000 (negative) and set sat_flag sticky until the next honoured start.
  - Adds a 24-bit signed add in this block; the MAC adder output is not used for the psum update.
- Undefined: wrap-around via the MAC output; sat_flag constant 0.

Decomposition:
- Package mac_pkg:
  - DATA_W/PSUM_W constants
  - state enum typedef {IDLE, ACCUM, DONE}
  - PSUM_MAX/PSUM_MIN constants
- One natural sub-module: the existing MAC, instantiated unchanged for the product and psum update.
- Counter and FSM stay in mac_accum_seq.

Test Plan:
- Nominal: KLEN=9, psum_init=0, nine pairs (3,4) back-to-back, out_ready=1 -> result=108 (0x00006C) one cycle after the 9th accept; out_valid high exactly 1 cycle.
- Corner operands: psum_init=-5, nine pairs (-128,-128) -> result=147451 (0x023FFB); a pair (-128,127) alone with KLEN=1 -> -16256 (0xFFC080).
- Stalls/backpressure: in_valid toggled 1/0 every cycle, then out_ready=0 for 5 cycles -> result matches the no-stall run, and result/out_valid are stable throughout the stall; in_ready=0 during DONE.
- Reset mid-op: rst_n=0 after 4 accepts, then start with psum_init=10 and nine pairs (1,1) -> result=19; no result from the aborted run.
- Overflow: psum_init=0x7FFFF0, KLEN=1, pair (127,127) -> without ACC_SAT_EN result=0x803EF1, sat_flag=0; with ACC_SAT_EN result=0x7FFFFF, sat_flag=1, cleared by the next start.
- Ignored start: start pulsed during ACCUM and DONE -> no state change and no psum reload; psum_init is sampled only from IDLE.
